// File: rtl/fog_phase_ramp_gen.sv
// fog_phase_ramp_gen: FOG closed-loop rate integrator, 2pi phase ramp and phase-modulator DAC word.
// Latency: trigger at edge T -> o_step at T+3, o_ramp at T+4, o_dac/o_rate_valid/o_ramp_sync at T+5.
// Backpressure: none; triggers arriving while busy are dropped and counted. Optional FOG_STEP_LIMIT_EN clamps o_step.
module fog_phase_ramp_gen #(
  parameter int          DAC_W    = 16,
  parameter logic [31:0] STEP_LIM = 32'h0400_0000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stepTrig,
  input  logic [31:0]      i_err,
  input  logic [4:0]       i_gain_sel,
  input  logic             i_loop_en,
  input  logic [31:0]      i_const_step,
  input  logic [31:0]      i_mod,
  output logic [31:0]      o_step,
  output logic [31:0]      o_ramp,
  output logic [DAC_W-1:0] o_dac,
  output logic             o_rate_valid,
  output logic             o_ramp_sync,
  output logic             o_busy,
  output logic [7:0]       o_trig_drop,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCALE = 3'd1,
    STEP  = 3'd2,
    RAMP  = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic signed [31:0] r_err;
  logic [4:0]         r_gain;
  logic               r_loop;
  logic [31:0]        r_cstep;
  logic signed [31:0] r_err_s;
  logic signed [31:0] r_step;
  logic [31:0]        r_ramp;
  logic               r_wrap;
  logic [DAC_W-1:0]   r_dac_i;
  logic               r_fire;
  logic               r_sync_i;
  logic [7:0]         r_drop;
  logic [31:0]        r_o_step;
  logic [31:0]        r_o_ramp;
  logic [DAC_W-1:0]   r_o_dac;
  logic               r_o_vld;
  logic               r_o_sync;

  logic signed [31:0] w_err_s;
  logic [32:0]        w_sum33;
  logic [31:0]        w_step_sat;
  logic [31:0]        w_step_new;
  logic [31:0]        w_step_lim;
  logic [32:0]        w_ramp_sum;
  logic [31:0]        w_phase;

  // Arithmetic shift floors toward -inf, which matches the signed error scaling.
  assign w_err_s    = r_err >>> r_gain;
  assign w_sum33    = {r_step[31], r_step} + {r_err_s[31], r_err_s};
  assign w_step_sat = (w_sum33[32] != w_sum33[31]) ?
                      (w_sum33[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : w_sum33[31:0];
  assign w_step_new = r_loop ? w_step_sat : r_cstep;

`ifdef FOG_STEP_LIMIT_EN
  logic signed [31:0] w_lim_pos;
  logic signed [31:0] w_lim_neg;
  assign w_lim_pos  = $signed(STEP_LIM);
  assign w_lim_neg  = -$signed(STEP_LIM);
  assign w_step_lim = ($signed(w_step_new) > w_lim_pos) ? w_lim_pos :
                      ($signed(w_step_new) < w_lim_neg) ? w_lim_neg : w_step_new;
`else
  assign w_step_lim = w_step_new;
`endif

  // The ramp is unsigned mod 2^32; a signed step wraps on carry (step >= 0) or borrow (step < 0).
  assign w_ramp_sum = {1'b0, r_ramp} + {1'b0, r_step};
  assign w_phase    = r_ramp + i_mod;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: a fixed walk through the update sequence, started by a trigger in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_stepTrig) w_state_nxt = SCALE;
      SCALE:   w_state_nxt = STEP;
      STEP:    w_state_nxt = RAMP;
      RAMP:    w_state_nxt = OUT;
      OUT:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: each state performs its one step of the update on the edge that leaves it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err    <= '0;
      r_gain   <= '0;
      r_loop   <= 1'b0;
      r_cstep  <= '0;
      r_err_s  <= '0;
      r_step   <= '0;
      r_ramp   <= '0;
      r_wrap   <= 1'b0;
      r_dac_i  <= '0;
      r_fire   <= 1'b0;
      r_sync_i <= 1'b0;
    end else begin
      r_fire <= 1'b0;
      case (r_state)
        IDLE: if (i_stepTrig) begin
          r_err   <= i_err;
          r_gain  <= i_gain_sel;
          r_loop  <= i_loop_en;
          r_cstep <= i_const_step;
        end
        SCALE: r_err_s <= w_err_s;
        STEP:  r_step  <= w_step_lim;
        RAMP: begin
          r_ramp <= w_ramp_sum[31:0];
          r_wrap <= r_step[31] ? ~w_ramp_sum[32] : w_ramp_sum[32];
        end
        OUT: begin
          r_dac_i  <= w_phase[31:32-DAC_W];
          r_fire   <= 1'b1;
          r_sync_i <= r_wrap;
        end
        default: ;
      endcase
    end
  end

  // Output stage: registered copies so every output lands one cycle after its internal value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_o_step <= '0;
      r_o_ramp <= '0;
      r_o_dac  <= '0;
      r_o_vld  <= 1'b0;
      r_o_sync <= 1'b0;
    end else begin
      r_o_step <= r_step;
      r_o_ramp <= r_ramp;
      r_o_dac  <= r_dac_i;
      r_o_vld  <= r_fire;
      r_o_sync <= r_fire & r_sync_i;
    end
  end

  // Saturating count of triggers that arrive while an update is in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_drop <= '0;
    else if (i_stepTrig && (r_state != IDLE) && (r_drop != 8'hFF))
      r_drop <= r_drop + 8'd1;
  end

  assign o_step       = r_o_step;
  assign o_ramp       = r_o_ramp;
  assign o_dac        = r_o_dac;
  assign o_rate_valid = r_o_vld;
  assign o_ramp_sync  = r_o_sync;
  assign o_busy       = (r_state != IDLE);
  assign o_trig_drop  = r_drop;
  assign o_state      = r_state;

endmodule

// File: tb/tb_fog_phase_ramp_gen.sv
// tb_fog_phase_ramp_gen: directed vectors with hand-computed expectations for fog_phase_ramp_gen.
// Latency: checks outputs at the documented T+3/T+4/T+5 points after each trigger.
// Backpressure: exercises dropped triggers and the saturating drop counter.
module tb_fog_phase_ramp_gen;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_stepTrig = 1'b0;
  logic [31:0] i_err = '0;
  logic [4:0]  i_gain_sel = '0;
  logic        i_loop_en = 1'b0;
  logic [31:0] i_const_step = '0;
  logic [31:0] i_mod = '0;
  logic [31:0] o_step;
  logic [31:0] o_ramp;
  logic [15:0] o_dac;
  logic        o_rate_valid;
  logic        o_ramp_sync;
  logic        o_busy;
  logic [7:0]  o_trig_drop;
  logic [2:0]  o_state;

  int total = 0;
  int bad   = 0;

  fog_phase_ramp_gen dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_stepTrig   (i_stepTrig),
    .i_err        (i_err),
    .i_gain_sel   (i_gain_sel),
    .i_loop_en    (i_loop_en),
    .i_const_step (i_const_step),
    .i_mod        (i_mod),
    .o_step       (o_step),
    .o_ramp       (o_ramp),
    .o_dac        (o_dac),
    .o_rate_valid (o_rate_valid),
    .o_ramp_sync  (o_ramp_sync),
    .o_busy       (o_busy),
    .o_trig_drop  (o_trig_drop),
    .o_state      (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_stepTrig = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // One full update; checks busy/state at T+1, step at T+3, ramp at T+4, valid/dac/sync at T+5.
  task automatic do_trig(input string tag, input logic [31:0] err, input logic [4:0] gain,
                         input logic loop, input logic [31:0] cstep, input logic [31:0] md,
                         input logic [31:0] exp_step, input logic [31:0] exp_ramp,
                         input logic [31:0] exp_dac, input logic exp_sync);
    @(negedge i_clk);
    i_err = err; i_gain_sel = gain; i_loop_en = loop; i_const_step = cstep; i_mod = md;
    i_stepTrig = 1'b1;
    @(posedge i_clk);
    #1 i_stepTrig = 1'b0;
    chk({tag, ".busy"}, {31'd0, o_busy}, 32'd1);
    @(posedge i_clk); @(posedge i_clk); @(posedge i_clk);
    #1 chk({tag, ".step"}, o_step, exp_step);
    @(posedge i_clk);
    #1 chk({tag, ".ramp"}, o_ramp, exp_ramp);
    chk({tag, ".vld_early"}, {31'd0, o_rate_valid}, 32'd0);
    @(posedge i_clk);
    #1 chk({tag, ".vld"}, {31'd0, o_rate_valid}, 32'd1);
    chk({tag, ".dac"}, {16'd0, o_dac}, exp_dac);
    chk({tag, ".sync"}, {31'd0, o_ramp_sync}, {31'd0, exp_sync});
    @(posedge i_clk);
    #1 chk({tag, ".vld_off"}, {31'd0, o_rate_valid}, 32'd0);
  endtask

  initial begin
    int vld_cnt;
    int vld_at;
    int seen;
    logic [31:0] r;

    // Reset held for 3 cycles with the trigger toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      i_stepTrig = (i != 1);
    end
    @(negedge i_clk);
    chk("rst.step",  o_step, 32'd0);
    chk("rst.ramp",  o_ramp, 32'd0);
    chk("rst.dac",   {16'd0, o_dac}, 32'd0);
    chk("rst.vld",   {31'd0, o_rate_valid}, 32'd0);
    chk("rst.sync",  {31'd0, o_ramp_sync}, 32'd0);
    chk("rst.busy",  {31'd0, o_busy}, 32'd0);
    chk("rst.state", {29'd0, o_state}, 32'd0);
    chk("rst.drop",  {24'd0, o_trig_drop}, 32'd0);
    i_stepTrig = 1'b0;
    i_rst = 1'b0;

    // Open loop, 16 steps of 0x1000_0000: the 16th wraps to 0.
    for (int k = 1; k <= 16; k++) begin
      r = 32'h1000_0000 * k;
      do_trig($sformatf("open%0d", k), 32'd0, 5'd0, 1'b0, 32'h1000_0000, 32'd0,
              32'h1000_0000, r, {16'd0, r[31:16]}, (k == 16));
      repeat (3) @(negedge i_clk);
    end

    // Closed-loop gain: 1000 >>> 2 = 250 per step; -1001 >>> 2 = -251.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      do_trig($sformatf("cl%0d", k), 32'd1000, 5'd2, 1'b1, 32'd0, 32'd0,
              32'd250 * k, 32'd250 * k * (k + 1) / 2, 32'd0, 1'b0);
    end
    do_trig("cl_neg", -32'sd1001, 5'd2, 1'b1, 32'd0, 32'd0, 32'd749, 32'd3249, 32'd0, 1'b0);

    // Positive saturation of the step register.
    do_reset();
    do_trig("pre", 32'd0, 5'd0, 1'b0, 32'h7FFF_FF00, 32'd0,
            32'h7FFF_FF00, 32'h7FFF_FF00, 32'h7FFF, 1'b0);
    do_trig("sat", 32'h1000, 5'd0, 1'b1, 32'd0, 32'd0,
            32'h7FFF_FFFF, 32'hFFFF_FEFF, 32'hFFFF, 1'b0);

    // Negative wrap: step -1 from ramp 0 borrows.
    do_reset();
    do_trig("negwrap", 32'd0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'd0,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF, 1'b1);

    // Modulation is added (with natural wrap) and only sampled during an update.
    do_reset();
    do_trig("mod1", 32'd0, 5'd0, 1'b0, 32'h1000_0000, 32'h0234_5678,
            32'h1000_0000, 32'h1000_0000, 32'h1234, 1'b0);
    @(negedge i_clk);
    i_mod = 32'h5555_0000;
    repeat (4) @(negedge i_clk);
    chk("mod_hold", {16'd0, o_dac}, 32'h1234);
    do_trig("mod2", 32'd0, 5'd0, 1'b0, 32'h1000_0000, 32'hF000_0000,
            32'h1000_0000, 32'h2000_0000, 32'h1000, 1'b0);

    // Collision: second pulse 2 cycles after the first is dropped.
    do_reset();
    @(negedge i_clk);
    i_loop_en = 1'b0; i_const_step = 32'h0100_0000; i_mod = 32'd0;
    i_stepTrig = 1'b1;
    @(posedge i_clk);
    #1 i_stepTrig = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_stepTrig = 1'b1;
    @(posedge i_clk);
    #1 i_stepTrig = 1'b0;
    vld_cnt = 0;
    vld_at = 0;
    for (int c = 3; c <= 12; c++) begin
      @(posedge i_clk);
      #1;
      if (o_rate_valid) begin
        vld_cnt++;
        vld_at = c;
      end
    end
    chk("coll.count", vld_cnt, 32'd1);
    chk("coll.cycle", vld_at, 32'd5);
    chk("coll.drop", {24'd0, o_trig_drop}, 32'd1);

    // Continuous trigger: 4 of every 5 pulses drop, so 400 cycles saturate at 255.
    do_reset();
    @(negedge i_clk);
    i_stepTrig = 1'b1;
    repeat (400) @(negedge i_clk);
    i_stepTrig = 1'b0;
    repeat (8) @(negedge i_clk);
    chk("drop.sat", {24'd0, o_trig_drop}, 32'd255);

    // Reset while in RAMP: the update is discarded.
    do_reset();
    @(negedge i_clk);
    i_loop_en = 1'b0; i_const_step = 32'h1000_0000; i_mod = 32'd0;
    i_stepTrig = 1'b1;
    @(posedge i_clk);
    #1 i_stepTrig = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge i_clk);
      if (o_state == 3'd3) seen = 1;
    end
    chk("mid.reached_ramp", seen, 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    vld_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge i_clk);
      #1 if (o_rate_valid) vld_cnt++;
    end
    chk("mid.vld", vld_cnt, 32'd0);
    chk("mid.step", o_step, 32'd0);
    chk("mid.ramp", o_ramp, 32'd0);
    chk("mid.state", {29'd0, o_state}, 32'd0);
    do_trig("mid.first", 32'd0, 5'd0, 1'b0, 32'h1000_0000, 32'd0,
            32'h1000_0000, 32'h1000_0000, 32'h1000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
